// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux8 scan sequencer
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    localparam int SEL_W     = 3;
    localparam int NUM_CH    = 8;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 16;
    localparam int DWELL_MIN = 1;
    localparam int DWELL_MAX = 65535;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - per-channel dwell counter, terminal count at DWELL-1
module dwell_counter
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == LAST);

    // Wraps to zero on terminal count so back-to-back dwells need no clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// rtl/mux8_scan_ctrl.sv - sweeps an 8:1 mux select and captures each channel
module mux8_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic [DATA_W-1:0] mux_o,
    output logic [SEL_W-1:0]  s,
    output logic [DATA_W-1:0] cap_data,
    output logic [SEL_W-1:0]  cap_idx,
    output logic              cap_valid,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sweep_sum
);

    scan_state_e       state, state_d;
    logic              tc;
    logic              capture;
    logic              last;
    logic [DATA_W-1:0] acc;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr ((state == IDLE) || abort),
        .en  ((state == SCAN) && !abort),
        .tc  (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Abort outranks the capture, including the final one of a sweep
    always_comb begin
        state_d = state;
        capture = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tc) begin
                    capture = 1'b1;
                    if (s == LAST_CH) begin
                        last = 1'b1;
                        if (!cont) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            acc       <= '0;
            cap_data  <= '0;
            cap_idx   <= '0;
            cap_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sweep_sum <= '0;
        end else begin
            busy      <= (state_d == SCAN);
            cap_valid <= capture;
            done      <= last;
            if ((state == IDLE) && start) begin
                s   <= '0;
                acc <= '0;
            end else if ((state == SCAN) && abort) begin
                s <= '0;
            end else if (capture) begin
                cap_data <= mux_o;
                cap_idx  <= s;
                if (last) begin
                    s         <= '0;
                    acc       <= '0;
                    sweep_sum <= acc + mux_o;
                end else begin
                    s   <= s + SEL_W'(1);
                    acc <= acc + mux_o;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb/tb_mux8_scan_ctrl.sv - directed self-checking bench for mux8_scan_ctrl
module tb_mux8_scan_ctrl;
    import mux_scan_pkg::*;

    localparam logic [31:0] SUM_A = 32'hFFFDDDDC;
    localparam logic [31:0] SUM_B = 32'hFFFFFFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, cont = 1'b0, abort = 1'b0;
    logic [31:0] ch [8];
    logic [31:0] mux_o;
    logic [2:0]  s, cap_idx;
    logic [31:0] cap_data, sweep_sum;
    logic        cap_valid, busy, done;

    logic        start_b = 1'b0, cont_b = 1'b0, abort_b = 1'b0;
    logic [31:0] mux_o_b;
    logic [2:0]  s_b, cap_idx_b;
    logic [31:0] cap_data_b, sweep_sum_b;
    logic        cap_valid_b, busy_b, done_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign mux_o   = ch[s];
    assign mux_o_b = 32'hFFFFFFFF;

    mux8_scan_ctrl #(.DWELL(4)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
        .mux_o(mux_o), .s(s), .cap_data(cap_data), .cap_idx(cap_idx),
        .cap_valid(cap_valid), .busy(busy), .done(done), .sweep_sum(sweep_sum)
    );

    mux8_scan_ctrl #(.DWELL(DWELL_MIN)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cont(cont_b), .abort(abort_b),
        .mux_o(mux_o_b), .s(s_b), .cap_data(cap_data_b), .cap_idx(cap_idx_b),
        .cap_valid(cap_valid_b), .busy(busy_b), .done(done_b), .sweep_sum(sweep_sum_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic ab);
        start = 1'b1;
        abort = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    // k counts edges after the start edge; a capture lands on every 4th edge
    task automatic scan_run(input int n, input int end_k, input int cont_clear_k,
                            input int abort_k, input int start_k);
        for (int k = 1; k <= n; k++) begin
            logic live, act, run, ev, dn;
            int   c;
            tick();
            live = (k < abort_k);
            act  = live && (k <= end_k);
            run  = live && (k < end_k);
            ev   = act && (k % 4 == 0);
            c    = ((k / 4) - 1) % 8;
            chk("cap_valid", cap_valid, ev);
            if (ev) begin
                chk("cap_idx", cap_idx, c);
                chk("cap_data", cap_data, ch[c]);
            end
            dn = act && (k % 32 == 0);
            chk("done", done, dn);
            if (dn) chk("sweep_sum", sweep_sum, SUM_A);
            chk("busy", busy, run);
            chk("s", s, run ? (k % 32) / 4 : 0);
            if (k == cont_clear_k) cont = 1'b0;
            abort = (k + 1 == abort_k);
            start = (k + 1 == start_k);
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            ch[i] = ((i % 2) ? 32'h55AA0000 : 32'hAA550000) | (32'(i) * 32'h1111);

        #12;
        chk("rst_s", s, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cap_valid", cap_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_cap_data", cap_data, 0);
        chk("rst_sweep_sum", sweep_sum, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // full sweep
        kick(1'b0);
        scan_run(40, 32, 0, 999, 0);

        // continuous: two full sweeps, cont cleared during the third
        cont = 1'b1;
        kick(1'b0);
        scan_run(100, 96, 70, 999, 0);

        // abort during channel 3, sum keeps the previous sweep's value
        kick(1'b0);
        scan_run(20, 32, 0, 14, 0);
        chk("abort_sum_kept", sweep_sum, SUM_A);

        // start and abort together in idle: start wins
        kick(1'b1);
        scan_run(40, 32, 0, 999, 0);

        // abort on the final capture edge: no done
        kick(1'b0);
        scan_run(36, 32, 0, 32, 0);
        chk("final_abort_sum", sweep_sum, SUM_A);

        // start while busy at channel 5 is ignored
        kick(1'b0);
        scan_run(40, 32, 0, 999, 21);

        // async reset between edges at channel 6
        kick(1'b0);
        scan_run(26, 32, 0, 999, 0);
        #3 rst = 1'b1;
        #1;
        chk("arst_s", s, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cap_data", cap_data, 0);
        chk("arst_cap_idx", cap_idx, 0);
        chk("arst_sweep_sum", sweep_sum, 0);
        chk("arst_cap_valid", cap_valid, 0);
        chk("arst_done", done, 0);
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_busy", busy, 0);
            chk("post_rst_s", s, 0);
            chk("post_rst_valid", cap_valid, 0);
        end

        // DWELL=1 with all-ones channels: consecutive captures, 32-bit wrap
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("b_cap_valid", cap_valid_b, k <= 8);
            if (k <= 8) begin
                chk("b_cap_idx", cap_idx_b, k - 1);
                chk("b_cap_data", cap_data_b, 32'hFFFFFFFF);
            end
            chk("b_done", done_b, k == 8);
            chk("b_busy", busy_b, k < 8);
            if (k == 8) chk("b_sweep_sum", sweep_sum_b, SUM_B);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux8_scan_ctrl.md
Name: mux8_scan_ctrl

Overview:
- Sequencer that sits around the 8-to-1 32-bit channel mux.
- Upstream, it drives the mux select `s` through channels 0..7, holding each channel for a programmable dwell time.
- Downstream, it captures the mux output `o` at the end of each dwell and presents each capture as a registered word with index and valid strobe.
- It also keeps a running 32-bit sum over the sweep, for the display and self-check logic.

Parameters:
- DWELL, 4: cycles each channel is held on `s` before capture; legal range 1..65535.
- NUM_CH, 8: channels per sweep; fixed at 8, matching the 3-bit select.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- cont  in  1  continuous mode; sampled at each sweep end.
- abort  in  1  stop the current sweep at the next edge.
- mux_o  in  32  output of the 8-to-1 mux (combinational from `s`).
- s  out  3  mux select, registered.
- cap_data  out  32  word captured from mux_o.
- cap_idx  out  3  channel number of cap_data.
- cap_valid  out  1  one-cycle strobe: cap_data/cap_idx updated this cycle.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle strobe: sweep finished normally.
- sweep_sum  out  32  sum mod 2^32 of the 8 captures of the last completed sweep.

Behaviour:
- Reset (async, any state): all outputs = 0; state = IDLE; dwell counter = 0; accumulator = 0.
- States: IDLE and SCAN.
- IDLE:
  - s = 0, busy = 0.
  - start=1 at an edge: go to SCAN, cnt = 0, s = 0, accumulator = 0, busy = 1 from the next cycle.
- SCAN, each edge:
  - If abort=1: go to IDLE, s = 0, busy = 0. No cap_valid, no done. sweep_sum is unchanged.
  - Else if cnt < DWELL-1: cnt += 1.
  - Else (cnt == DWELL-1), capture:
    - cap_data = mux_o, cap_idx = s, cap_valid = 1 for exactly one cycle.
    - accumulator += mux_o, 32-bit wrap, no carry out.
    - cnt = 0.
    - If s < 7: s += 1.
    - If s == 7:
      - sweep_sum = accumulator + mux_o.
      - done = 1 for one cycle, in the same cycle as the 8th cap_valid.
      - s = 0.
      - If cont=1: remain in SCAN with accumulator = 0; busy stays 1, with no gap between sweeps.
      - Else: go to IDLE with busy = 0.
- Timing:
  - mux_o settles combinationally within the dwell; it is sampled DWELL cycles after s changes.
  - With DWELL=1, s changes every cycle and the capture uses the value selected during that cycle.
  - One sweep lasts 8*DWELL cycles; done asserts 8*DWELL cycles after the start edge.
- Boundary and precedence rules:
  - start while busy: ignored.
  - abort in IDLE: ignored.
  - abort in the same cycle as the final capture: abort wins, no done.
  - start and abort together in IDLE: start wins.
  - cont is sampled only at the capture of channel 7; clearing cont mid-sweep finishes the current sweep and then goes to IDLE.
  - cap_data, cap_idx and sweep_sum hold their values until overwritten; cap_valid and done are strobes only.
  - rst asserted mid-sweep: immediate return to reset values, no done.

Decomposition:
- Shared package `mux_scan_pkg`:
  - state enum {IDLE, SCAN};
  - constants SEL_W=3, NUM_CH=8, DATA_W=32;
  - DWELL bounds (1..65535), used by the bench and assertions.
- Sub-module `dwell_counter`:
  - 16-bit counter with clear and enable;
  - terminal-count output at DWELL-1;
  - asynchronous reset.
- Select register, accumulator and FSM stay in the top module.

Test Plan:
- Channel values I0..I7 = AA550000, 55AA1111, AA552222, 55AA3333, AA554444, 55AA5555, AA556666, 55AA7777.
- 1. Full sweep: channels loaded as above, DWELL=4, pulse start → s steps 0..7 every 4 cycles; 8 cap_valid strobes with cap_idx 0..7 and cap_data equal to I0..I7; done 32 cycles after the start edge; sweep_sum = FFFDDDDC; busy returns to 0.
- 2. Continuous mode: cont=1 through two sweeps → 16 back-to-back captures, with no idle cycle between the 8th and 9th; sweep_sum = FFFDDDDC after each done. Clear cont during sweep 3 → exactly one more done, then IDLE.
- 3. Abort: abort during channel 3 dwell → no further cap_valid, no done, s=0, busy=0, sweep_sum keeps its prior value; a new start then runs a clean sweep.
- 4. Start while busy: pulse start at channel 5 → no restart; the capture sequence is unchanged.
- 5. Async reset mid-sweep: rst pulse between edges at channel 6 → all outputs 0 immediately, without waiting for a clock edge; after release the block stays IDLE until start.
- 6. DWELL=1 and wrap: DWELL=1, all channels = FFFFFFFF → 8 consecutive cap_valid cycles; sweep_sum = FFFFFFF8, showing the 32-bit wrap.
